// File: rtl/axis_drop_monitor_if.sv
// Tapped AXI-Stream handshake bundle for axis_drop_monitor.
// The stream owner drives it through the master modport; the monitor only
// observes it through the slave modport.
interface axis_drop_monitor_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned KEEP_W = 64
);
  logic [NUM_CH-1:0]        mon_tvalid;
  logic [NUM_CH-1:0]        mon_tready;
  logic [NUM_CH-1:0]        mon_tlast;
  logic [NUM_CH*KEEP_W-1:0] mon_tkeep;

  modport master (
    output mon_tvalid,
    output mon_tready,
    output mon_tlast,
    output mon_tkeep
  );

  modport slave (
    input mon_tvalid,
    input mon_tready,
    input mon_tlast,
    input mon_tkeep
  );
endinterface

// File: rtl/axis_drop_monitor.sv
// Passive multi-channel AXI-Stream tap: per-channel packet/byte counters,
// frame-format checking and "expect drop" violation detection.
module axis_drop_monitor #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned KEEP_W    = 64,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_BEATS = 24
) (
  input  logic                    axis_aclk,
  input  logic                    areset,
  axis_drop_monitor_if.slave      mon,
  input  logic [NUM_CH-1:0]       cfg_expect_drop,
  input  logic                    clr,
  output logic [NUM_CH*CNT_W-1:0] pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0] byte_cnt,
  output logic [NUM_CH-1:0]       in_pkt,
  output logic [NUM_CH-1:0]       drop_viol,
  output logic [NUM_CH-1:0]       fmt_err,
  output logic                    viol_pulse
);

  localparam int unsigned POP_W  = $clog2(KEEP_W + 1);
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [KEEP_W-1:0] v);
    logic [POP_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) p = p + POP_W'(v[i]);
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [POP_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [BEAT_W-1:0] beat_q  [NUM_CH];
  logic [BEAT_W-1:0] beat_d  [NUM_CH];
  logic [CNT_W-1:0]  pkt_q   [NUM_CH];
  logic [CNT_W-1:0]  pkt_d   [NUM_CH];
  logic [CNT_W-1:0]  byte_q  [NUM_CH];
  logic [CNT_W-1:0]  byte_d  [NUM_CH];
  logic [NUM_CH-1:0] drop_q, drop_d;
  logic [NUM_CH-1:0] fmt_q, fmt_d;
  logic              pulse_q, pulse_d;

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] keep_full;
  logic [NUM_CH-1:0] last_ok;
  logic [POP_W-1:0]  pop [NUM_CH];

  // Per-channel beat decode: accept, keep shape checks and byte count.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [KEEP_W-1:0] keep;
    assign keep         = mon.mon_tkeep[c*KEEP_W +: KEEP_W];
    assign acc[c]       = mon.mon_tvalid[c] & mon.mon_tready[c];
    assign keep_full[c] = &keep;
    // Legal last-beat keep is 2^k-1 with k >= 1: nonzero, contiguous from bit 0.
    assign last_ok[c]   = (keep != '0) && ((keep & (keep + KEEP_W'(1))) == '0);
    assign pop[c]       = popcount(keep);
  end

  // Next-state: framing FSM, counters and sticky flags for every channel.
  always_comb begin
    drop_d = clr ? '0 : drop_q;
    fmt_d  = clr ? '0 : fmt_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      beat_d[c]  = beat_q[c];
      pkt_d[c]   = clr ? '0 : pkt_q[c];
      byte_d[c]  = clr ? '0 : byte_q[c];
      if (acc[c]) begin
        byte_d[c] = sat_add(byte_d[c], pop[c]);
        if (mon.mon_tlast[c]) pkt_d[c] = sat_add(pkt_d[c], POP_W'(1));
        if (cfg_expect_drop[c]) drop_d[c] = 1'b1;
        if (!mon.mon_tlast[c] && !keep_full[c]) fmt_d[c] = 1'b1;
        if (mon.mon_tlast[c] && !last_ok[c]) fmt_d[c] = 1'b1;
        case (state_q[c])
          IDLE: begin
            if (!mon.mon_tlast[c]) begin
              state_d[c] = BODY;
              beat_d[c]  = BEAT_W'(1);
            end
          end
          BODY: begin
            // Overlong packet: abandon framing so the next beat starts fresh.
            if (beat_q[c] >= BEAT_W'(MAX_BEATS)) begin
              fmt_d[c]   = 1'b1;
              state_d[c] = IDLE;
              beat_d[c]  = '0;
            end else if (mon.mon_tlast[c]) begin
              state_d[c] = IDLE;
              beat_d[c]  = '0;
            end else begin
              beat_d[c] = beat_q[c] + BEAT_W'(1);
            end
          end
          default: begin
            state_d[c] = IDLE;
            beat_d[c]  = '0;
          end
        endcase
      end
    end
    // Compare against the pre-edge flags so a clr that reloads an already-set
    // bit does not count as a fresh violation.
    pulse_d = |((drop_d & ~drop_q) | (fmt_d & ~fmt_q));
  end

  // State, counter and flag registers with asynchronous reset.
  always_ff @(posedge axis_aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        beat_q[c]  <= '0;
        pkt_q[c]   <= '0;
        byte_q[c]  <= '0;
      end
      drop_q  <= '0;
      fmt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        beat_q[c]  <= beat_d[c];
        pkt_q[c]   <= pkt_d[c];
        byte_q[c]  <= byte_d[c];
      end
      drop_q  <= drop_d;
      fmt_q   <= fmt_d;
      pulse_q <= pulse_d;
    end
  end

  // Flatten per-channel registers onto the packed output buses.
  always_comb begin
    pkt_cnt  = '0;
    byte_cnt = '0;
    in_pkt   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pkt_cnt[c*CNT_W +: CNT_W]  = pkt_q[c];
      byte_cnt[c*CNT_W +: CNT_W] = byte_q[c];
      in_pkt[c]                  = (state_q[c] == BODY);
    end
  end

  assign drop_viol  = drop_q;
  assign fmt_err    = fmt_q;
  assign viol_pulse = pulse_q;

endmodule

// File: tb/tb_axis_drop_monitor.sv
// Self-checking bench for axis_drop_monitor: a 32-bit-counter instance for
// framing/flag behaviour and an 8-bit-counter instance for saturation.
module tb_axis_drop_monitor;

  typedef struct {
    int unsigned ch;
    logic [31:0] pkt;
    logic [31:0] bytes;
    logic [1:0]  drop;
    logic [1:0]  fmt;
  } exp_t;

  logic        clk;
  logic        areset;
  logic [1:0]  cfg_expect_drop;
  logic        clr;
  logic [63:0] pkt_cnt, byte_cnt;
  logic [1:0]  in_pkt, drop_viol, fmt_err;
  logic        viol_pulse;

  logic [1:0]  cfg8;
  logic        clr8;
  logic [15:0] pkt8, byte8;
  logic [1:0]  in_pkt8, drop8, fmt8;
  logic        pulse8;

  int checks;
  int failures;
  exp_t sbq[$];
  exp_t e;

  axis_drop_monitor_if #(.NUM_CH(2), .KEEP_W(64)) bus ();
  axis_drop_monitor_if #(.NUM_CH(2), .KEEP_W(64)) bus8 ();

  axis_drop_monitor #(.NUM_CH(2), .KEEP_W(64), .CNT_W(32), .MAX_BEATS(24)) dut (
    .axis_aclk      (clk),
    .areset         (areset),
    .mon            (bus),
    .cfg_expect_drop(cfg_expect_drop),
    .clr            (clr),
    .pkt_cnt        (pkt_cnt),
    .byte_cnt       (byte_cnt),
    .in_pkt         (in_pkt),
    .drop_viol      (drop_viol),
    .fmt_err        (fmt_err),
    .viol_pulse     (viol_pulse)
  );

  axis_drop_monitor #(.NUM_CH(2), .KEEP_W(64), .CNT_W(8), .MAX_BEATS(24)) dut8 (
    .axis_aclk      (clk),
    .areset         (areset),
    .mon            (bus8),
    .cfg_expect_drop(cfg8),
    .clr            (clr8),
    .pkt_cnt        (pkt8),
    .byte_cnt       (byte8),
    .in_pkt         (in_pkt8),
    .drop_viol      (drop8),
    .fmt_err        (fmt8),
    .viol_pulse     (pulse8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One beat on channel ch, presented for exactly one rising edge.
  task automatic drive(input int unsigned ch, input logic [63:0] keep,
                       input logic last, input logic rdy);
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    bus.mon_tlast  = '0;
    bus.mon_tkeep  = '0;
    bus.mon_tvalid[ch]         = 1'b1;
    bus.mon_tready[ch]         = rdy;
    bus.mon_tlast[ch]          = last;
    bus.mon_tkeep[ch*64 +: 64] = keep;
    @(posedge clk); #1;
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    bus.mon_tlast  = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({pkt_cnt, byte_cnt} !== 128'd0) begin
      failures++; $display("FAIL reset_counters: got %0h want 0", {pkt_cnt, byte_cnt});
    end
    @(posedge clk); #1;
    checks++;
    if ({in_pkt, drop_viol, fmt_err, viol_pulse} !== 7'd0) begin
      failures++; $display("FAIL reset_flags: got %b want 0", {in_pkt, drop_viol, fmt_err, viol_pulse});
    end
    checks++;
    if ({pkt8, byte8, in_pkt8, drop8, fmt8, pulse8} !== 39'd0) begin
      failures++; $display("FAIL reset_dut8: got %0h want 0", {pkt8, byte8, in_pkt8, drop8, fmt8, pulse8});
    end
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_packet();
    do_clr();
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1);
    checks++;
    if (in_pkt !== 2'b01) begin
      failures++; $display("FAIL basic_in_pkt_mid: got %b want 01", in_pkt);
    end
    sbq.push_back('{ch: 0, pkt: 32'd1, bytes: 32'd84, drop: 2'b00, fmt: 2'b00});
    drive(0, 64'h0000_0000_000f_ffff, 1'b1, 1'b1);
    checks++;
    if (in_pkt !== 2'b00) begin
      failures++; $display("FAIL basic_in_pkt_end: got %b want 00", in_pkt);
    end
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse}
        !== {e.pkt, e.bytes, e.drop, e.fmt, 1'b0}) begin
      failures++;
      $display("FAIL basic_counts: got pkt=%0d bytes=%0d drop=%b fmt=%b pulse=%b want pkt=%0d bytes=%0d drop=%b fmt=%b pulse=0",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse,
               e.pkt, e.bytes, e.drop, e.fmt);
    end
  endtask

  task automatic test_drop();
    do_clr();
    cfg_expect_drop = 2'b11;
    sbq.push_back('{ch: 1, pkt: 32'd1, bytes: 32'd64, drop: 2'b10, fmt: 2'b00});
    drive(1, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse}
        !== {e.pkt, e.bytes, e.drop, e.fmt, 1'b1}) begin
      failures++;
      $display("FAIL drop_first: got pkt=%0d bytes=%0d drop=%b fmt=%b pulse=%b want pkt=%0d bytes=%0d drop=%b fmt=%b pulse=1",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse,
               e.pkt, e.bytes, e.drop, e.fmt);
    end
    @(posedge clk); #1;
    checks++;
    if (viol_pulse !== 1'b0) begin
      failures++; $display("FAIL drop_pulse_width: got %b want 0", viol_pulse);
    end
    sbq.push_back('{ch: 1, pkt: 32'd2, bytes: 32'd128, drop: 2'b10, fmt: 2'b00});
    drive(1, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse}
        !== {e.pkt, e.bytes, e.drop, e.fmt, 1'b0}) begin
      failures++;
      $display("FAIL drop_second: got pkt=%0d bytes=%0d drop=%b fmt=%b pulse=%b want pkt=%0d bytes=%0d drop=%b fmt=%b pulse=0",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse,
               e.pkt, e.bytes, e.drop, e.fmt);
    end
    cfg_expect_drop = 2'b00;
    do_clr();
    checks++;
    if ({drop_viol, viol_pulse, pkt_cnt} !== 67'd0) begin
      failures++; $display("FAIL drop_clr: got drop=%b pulse=%b pkt=%0h want all 0", drop_viol, viol_pulse, pkt_cnt);
    end
  endtask

  task automatic test_format();
    do_clr();
    drive(0, 64'hffff_ffff_ffff_fffe, 1'b0, 1'b1);
    checks++;
    if ({fmt_err, viol_pulse, in_pkt} !== 5'b01_1_01) begin
      failures++; $display("FAIL fmt_nonlast_keep: got fmt=%b pulse=%b in_pkt=%b want 01 1 01", fmt_err, viol_pulse, in_pkt);
    end
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    checks++;
    if ({fmt_err, viol_pulse, in_pkt} !== 5'b01_0_00) begin
      failures++; $display("FAIL fmt_sticky: got fmt=%b pulse=%b in_pkt=%b want 01 0 00", fmt_err, viol_pulse, in_pkt);
    end
    do_clr();
    drive(0, 64'h0000_0000_0000_0005, 1'b1, 1'b1);
    checks++;
    if ({fmt_err, pkt_cnt[31:0]} !== {2'b01, 32'd1}) begin
      failures++; $display("FAIL fmt_last_gap: got fmt=%b pkt=%0d want fmt=01 pkt=1", fmt_err, pkt_cnt[31:0]);
    end
    do_clr();
    sbq.push_back('{ch: 0, pkt: 32'd1, bytes: 32'd5, drop: 2'b00, fmt: 2'b00});
    drive(0, 64'h0000_0000_0000_001f, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err}
        !== {e.pkt, e.bytes, e.drop, e.fmt}) begin
      failures++;
      $display("FAIL fmt_last_legal: got pkt=%0d bytes=%0d drop=%b fmt=%b want pkt=%0d bytes=%0d drop=%b fmt=%b",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, e.pkt, e.bytes, e.drop, e.fmt);
    end
    sbq.push_back('{ch: 0, pkt: 32'd2, bytes: 32'd5, drop: 2'b00, fmt: 2'b01});
    drive(0, 64'h0, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err}
        !== {e.pkt, e.bytes, e.drop, e.fmt}) begin
      failures++;
      $display("FAIL fmt_last_zero: got pkt=%0d bytes=%0d drop=%b fmt=%b want pkt=%0d bytes=%0d drop=%b fmt=%b",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, e.pkt, e.bytes, e.drop, e.fmt);
    end
  endtask

  task automatic test_max_beats();
    do_clr();
    for (int i = 0; i < 24; i++) drive(0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1);
    checks++;
    if ({in_pkt, fmt_err} !== 4'b01_00) begin
      failures++; $display("FAIL max_beat24: got in_pkt=%b fmt=%b want 01 00", in_pkt, fmt_err);
    end
    sbq.push_back('{ch: 0, pkt: 32'd0, bytes: 32'd1600, drop: 2'b00, fmt: 2'b01});
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt, viol_pulse}
        !== {e.pkt, e.bytes, e.fmt, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL max_beat25: got pkt=%0d bytes=%0d fmt=%b in_pkt=%b pulse=%b want pkt=%0d bytes=%0d fmt=%b in_pkt=00 pulse=1",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt, viol_pulse, e.pkt, e.bytes, e.fmt);
    end
    do_clr();
    sbq.push_back('{ch: 0, pkt: 32'd1, bytes: 32'd64, drop: 2'b00, fmt: 2'b00});
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt}
        !== {e.pkt, e.bytes, e.fmt, 2'b00}) begin
      failures++;
      $display("FAIL max_recover: got pkt=%0d bytes=%0d fmt=%b in_pkt=%b want pkt=%0d bytes=%0d fmt=%b in_pkt=00",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt, e.pkt, e.bytes, e.fmt);
    end
  endtask

  task automatic test_stall_and_clr();
    do_clr();
    for (int i = 0; i < 10; i++) begin
      drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0);
      checks++;
      if ({pkt_cnt, byte_cnt, in_pkt} !== 130'd0) begin
        failures++; $display("FAIL stall_cycle%0d: got pkt=%0h bytes=%0h in_pkt=%b want 0", i, pkt_cnt, byte_cnt, in_pkt);
      end
    end
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    checks++;
    if ({pkt_cnt[31:0], byte_cnt[31:0]} !== {32'd1, 32'd64}) begin
      failures++; $display("FAIL stall_accept: got pkt=%0d bytes=%0d want pkt=1 bytes=64", pkt_cnt[31:0], byte_cnt[31:0]);
    end
    cfg_expect_drop = 2'b01;
    clr = 1'b1;
    sbq.push_back('{ch: 0, pkt: 32'd1, bytes: 32'd64, drop: 2'b01, fmt: 2'b00});
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    clr = 1'b0;
    cfg_expect_drop = 2'b00;
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse}
        !== {e.pkt, e.bytes, e.drop, e.fmt, 1'b1}) begin
      failures++;
      $display("FAIL clr_with_beat: got pkt=%0d bytes=%0d drop=%b fmt=%b pulse=%b want pkt=%0d bytes=%0d drop=%b fmt=%b pulse=1",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], drop_viol, fmt_err, viol_pulse,
               e.pkt, e.bytes, e.drop, e.fmt);
    end
  endtask

  task automatic test_simultaneous();
    do_clr();
    bus.mon_tvalid = 2'b11;
    bus.mon_tready = 2'b11;
    bus.mon_tlast  = 2'b11;
    bus.mon_tkeep  = {64'h0000_0000_0000_ffff, 64'h0000_0000_0000_00ff};
    @(posedge clk); #1;
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    bus.mon_tlast  = '0;
    checks++;
    if ({pkt_cnt, byte_cnt} !== {32'd1, 32'd1, 32'd16, 32'd8}) begin
      failures++; $display("FAIL simultaneous: got pkt=%0h bytes=%0h want pkt=1,1 bytes=16,8", pkt_cnt, byte_cnt);
    end
  endtask

  task automatic test_saturate();
    bus8.mon_tvalid = 2'b01;
    bus8.mon_tready = 2'b01;
    bus8.mon_tlast  = 2'b01;
    bus8.mon_tkeep  = {64'h0, 64'h0000_0000_0000_0001};
    repeat (255) @(posedge clk);
    #1;
    checks++;
    if ({pkt8, byte8} !== {8'd0, 8'd255, 8'd0, 8'd255}) begin
      failures++; $display("FAIL sat_reach: got pkt=%0h bytes=%0h want pkt=00ff bytes=00ff", pkt8, byte8);
    end
    repeat (45) @(posedge clk);
    #1;
    bus8.mon_tvalid = '0;
    bus8.mon_tready = '0;
    checks++;
    if ({pkt8, byte8, fmt8} !== {8'd0, 8'd255, 8'd0, 8'd255, 2'b00}) begin
      failures++; $display("FAIL sat_hold: got pkt=%0h bytes=%0h fmt=%b want pkt=00ff bytes=00ff fmt=00", pkt8, byte8, fmt8);
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1);
    checks++;
    if ({in_pkt, byte_cnt[31:0]} !== {2'b01, 32'd64}) begin
      failures++; $display("FAIL areset_setup: got in_pkt=%b bytes=%0d want 01 64", in_pkt, byte_cnt[31:0]);
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({pkt_cnt, byte_cnt, in_pkt, drop_viol, fmt_err, viol_pulse, pkt8, byte8} !== 167'd0) begin
      failures++; $display("FAIL areset_async: got pkt=%0h bytes=%0h in_pkt=%b pkt8=%0h want all 0",
                           pkt_cnt, byte_cnt, in_pkt, pkt8);
    end
    @(posedge clk); #1;
    areset = 1'b0;
    sbq.push_back('{ch: 0, pkt: 32'd1, bytes: 32'd64, drop: 2'b00, fmt: 2'b00});
    drive(0, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt}
        !== {e.pkt, e.bytes, e.fmt, 2'b00}) begin
      failures++;
      $display("FAIL areset_after: got pkt=%0d bytes=%0d fmt=%b in_pkt=%b want pkt=%0d bytes=%0d fmt=%b in_pkt=00",
               pkt_cnt[e.ch*32 +: 32], byte_cnt[e.ch*32 +: 32], fmt_err, in_pkt, e.pkt, e.bytes, e.fmt);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cfg_expect_drop = '0;
    clr             = 1'b0;
    cfg8            = '0;
    clr8            = 1'b0;
    bus.mon_tvalid  = '0;
    bus.mon_tready  = '0;
    bus.mon_tlast   = '0;
    bus.mon_tkeep   = '0;
    bus8.mon_tvalid = '0;
    bus8.mon_tready = '0;
    bus8.mon_tlast  = '0;
    bus8.mon_tkeep  = '0;

    test_reset();
    test_basic_packet();
    test_drop();
    test_format();
    test_max_beats();
    test_stall_and_clr();
    test_simultaneous();
    test_saturate();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
